// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and counter sizing.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared 2*WIDTH accumulator datapath: one shift-add (multiply) or one
// restoring shift-subtract (divide) step per enabled cycle.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               is_div_i,
    input  logic [WIDTH-1:0]   load_hi_i,
    input  logic [WIDTH-1:0]   load_lo_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH:0]     lhs, rhs, sum;

    // Divide subtracts via inverted operand plus carry-in, sharing the adder.
    always_comb begin
        lhs = is_div_i ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        rhs = is_div_i ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
        sum = lhs + rhs + {{WIDTH{1'b0}}, is_div_i};
        if (is_div_i) begin
            if (!sum[WIDTH])
                acc_d = {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
            if (acc_q[0])
                acc_d = {sum, acc_q[WIDTH-1:1]};
            else
                acc_d = {1'b0, acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
        end else if (load_i) begin
            acc_q  <= {load_hi_i, load_lo_i};
            opnd_q <= opnd_i;
        end else if (step_i) begin
            acc_q  <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: FSM, sign handling and HI/LO registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; divide stays iterative.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               is_div_q, neg_res_q, neg_dvd_q, zero_q;
    logic               busy_q, done_q, dbz_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               is_signed, is_mul, is_dv, accept, b_zero;
    logic [WIDTH-1:0]   abs_a, abs_b, load_hi, load_lo, opnd;
    logic [2*WIDTH-1:0] acc, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        is_signed = ~op[0];
        is_mul    = (op[2:1] == 2'b00);
        is_dv     = (op[2:1] == 2'b01);
        b_zero    = (b == '0);
        accept    = (state_q == IDLE) && start;
        abs_a     = (is_signed && a[WIDTH-1]) ? -a : a;
        abs_b     = (is_signed && b[WIDTH-1]) ? -b : b;
        opnd      = is_mul ? abs_a : abs_b;
        load_hi   = '0;
        load_lo   = is_mul ? abs_b : abs_a;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] prod_fast;
    always_comb begin
        prod_fast = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
    end
`endif

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (accept && (is_mul || is_dv)),
        .step_i    (state_q == CALC),
        .is_div_i  (is_div_q),
`ifdef MULDIV_FAST_MUL_EN
        .load_hi_i (is_mul ? prod_fast[2*WIDTH-1:WIDTH] : load_hi),
        .load_lo_i (is_mul ? prod_fast[WIDTH-1:0] : load_lo),
`else
        .load_hi_i (load_hi),
        .load_lo_i (load_lo),
`endif
        .opnd_i    (opnd),
        .acc_o     (acc)
    );

    always_comb begin
        prod_fix = neg_res_q ? -acc : acc;
        quo_fix  = neg_res_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_dvd_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_dvd_q <= 1'b0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MTHI) begin
                            hi_q <= a;
                        end else if (op == OP_MTLO) begin
                            lo_q <= a;
                        end else if (is_mul || is_dv) begin
                            is_div_q  <= is_dv;
                            neg_res_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_dvd_q <= is_signed && a[WIDTH-1];
                            zero_q    <= is_dv && b_zero;
                            cnt_q     <= '0;
                            busy_q    <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                            state_q   <= (is_mul || b_zero) ? FIX : CALC;
`else
                            state_q   <= (is_dv && b_zero) ? FIX : CALC;
`endif
                        end
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1))
                        state_q <= FIX;
                end
                FIX: begin
                    if (!zero_q) begin
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                    done_q  <= 1'b1;
                    dbz_q   <= zero_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO/flag/latency,
// a negedge monitor pops and compares whenever done pulses.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                e = sbq.pop_front();
                chk("sb_hi", hi, e.hi);
                chk("sb_lo", lo, e.lo);
                chk("sb_dbz", {31'b0, div_by_zero}, {31'b0, e.dbz});
                chk("sb_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input bit push, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input logic edbz, input int lat);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        if (push) sbq.push_back('{hi: ehi, lo: elo, dbz: edbz, due: cyc + lat});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d expected=0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 1'b0, MUL_LAT);
        drain();
        issue(OP_MULT, 32'hFFFFFFFD, 32'd7, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, MUL_LAT);
        drain();
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT);
        drain();
        issue(OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0, DIV_LAT);
        drain();

        issue(OP_MTHI, 32'hAAAA5555, 32'h0, 0, '0, '0, 1'b0, 0);
        chk("mthi_hi", hi, 32'hAAAA5555);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        issue(OP_MTLO, 32'h12345678, 32'h0, 0, '0, '0, 1'b0, 0);
        chk("mtlo_lo", lo, 32'h12345678);
        chk("mtlo_busy", {31'b0, busy}, 32'd0);
        issue(3'b110, 32'hDEADBEEF, 32'd3, 0, '0, '0, 1'b0, 0);
        chk("op110_busy", {31'b0, busy}, 32'd0);
        chk("op110_hi", hi, 32'hAAAA5555);
        chk("op110_lo", lo, 32'h12345678);
        @(negedge clk);

        issue(OP_DIVU, 32'd100, 32'd0, 1, 32'hAAAA5555, 32'h12345678, 1'b1, 1);
        chk("dbz_busy", {31'b0, busy}, 32'd1);
        drain();

        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h00000000, 32'h80000000, 1'b0, DIV_LAT);
        repeat (5) @(negedge clk);
        issue(OP_MULTU, 32'd6, 32'd7, 0, '0, '0, 1'b0, 0);
        chk("ignored_start_busy", {31'b0, busy}, 32'd1);
        chk("midop_hi_hold", hi, 32'hAAAA5555);
        drain();
        repeat (40) @(negedge clk);
        chk("after_ignore_hi", hi, 32'h00000000);
        chk("after_ignore_lo", lo, 32'h80000000);

        issue(OP_DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 1'b0, DIV_LAT);
        for (int i = 0; i < 100 && done !== 1'b1; i++) @(negedge clk);
        chk("b2b_done_seen", {31'b0, done}, 32'd1);
        issue(OP_MULTU, 32'h00010000, 32'h00010000, 1, 32'h00000001, 32'h00000000, 1'b0, MUL_LAT);
        drain();

        issue(OP_DIVU, 32'h0000FFFF, 32'd3, 0, '0, '0, 1'b0, 0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi, 32'h0);
        chk("abort_lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(OP_MULTU, 32'd6, 32'd7, 1, 32'd0, 32'd42, 1'b0, MUL_LAT);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
